conv_window: RTL and testbench
==============================

CONV_WINDOW -- requirements
Module: conv_window

Interface
REQ-001 SHALL have parameter: MAX_WIDTH, 16, maximum image width and line-buffer depth in pixels.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: clear  input  1  synchronous frame abort/restart.
REQ-005 SHALL have port: img_width  input  5  image width in pixels, legal 3..MAX_WIDTH.
REQ-006 SHALL have port: img_height  input  5  image height in rows, legal 3..31.
REQ-007 SHALL have port: pixel_in  input  4  raster-order pixel.
REQ-008 SHALL have port: pixel_valid  input  1  pixel_in valid.
REQ-009 SHALL have port: pixel_ready  output  1  pixel accepted when pixel_valid and pixel_ready are both high.
REQ-010 SHALL have port: sample_out  output  36  3x3 window, nine 4-bit nibbles, to the multiplier/adder sample input.
REQ-011 SHALL have port: conv_en  output  1  one-cycle window-valid strobe to the multiplier/adder.
REQ-012 SHALL have port: frame_done  output  1  one-cycle pulse after the last pixel of a frame.
REQ-013 SHALL have port: cfg_err  output  1  latched illegal-geometry flag for the current frame.

Function
REQ-014 SHALL track col (0..W-1) and row (0..H-1) of the next pixel; col wraps to 0 and row increments on each accepted pixel with col=W-1.
REQ-015 SHALL sample img_width/img_height as W/H on the accept with row=0, col=0; they are ignored at all other times.
REQ-016 SHALL keep two line buffers, each MAX_WIDTH x 4 bits, holding rows row-1 and row-2, plus a 3x3 register window shifted left by one column per accept.
REQ-017 SHALL pack sample_out as nibble k = 3*r + c, with k at bits [4k+3:4k], r=0 the oldest row, c=0 the oldest column; nibble 8 is the pixel just accepted.
REQ-018 SHALL use FSM states ACCEPT, ISSUE and HOLD; reset state is ACCEPT.
REQ-019 In ACCEPT, pixel_ready SHALL be 1; an accept with row>=2, col>=2 and cfg_err=0 SHALL move to ISSUE; otherwise the FSM stays in ACCEPT.
REQ-020 In ISSUE, conv_en SHALL be 1 and pixel_ready 0 for exactly one cycle, then the FSM SHALL move to HOLD.
REQ-021 In HOLD, which is the multiplier/adder result_ready cycle, pixel_ready SHALL be 0 and the FSM SHALL then return to ACCEPT.
REQ-022 sample_out SHALL remain stable from the ISSUE cycle through the HOLD cycle.
REQ-023 conv_en SHALL never be high on two consecutive cycles.
REQ-024 Latency: conv_en SHALL be high on the cycle immediately after the completing accept.
REQ-025 On the accept of pixel (H-1, W-1), frame_done SHALL pulse in the next cycle and row/col SHALL return to 0; a final window's ISSUE/HOLD sequence still completes.
REQ-026 If the sampled W or H is outside its legal range, cfg_err SHALL be set; pixels are accepted and discarded with no conv_en, and frame_done and cfg_err clear occur at the end of the frame under the sampled geometry (W clamped to 3..MAX_WIDTH).
REQ-027 clear SHALL force ACCEPT, row=col=0 and cfg_err=0 on the next edge and SHALL win over a simultaneous accept; a clear in ISSUE drops conv_en on the next cycle.
REQ-028 Line buffer and window contents SHALL need no clearing, because REQ-019 gating prevents stale data from ever being issued.

Reset
REQ-029 n_rst low SHALL asynchronously force ACCEPT, row=col=0, conv_en=0, frame_done=0, cfg_err=0, sample_out=0 and pixel_ready=1 once released; data-path memories are not reset.

Structure
REQ-030 Package conv_pkg SHALL hold PIX_W=4, KERNEL=3, typedef window_t (logic [35:0]) and the FSM state enum.
REQ-031 Sub-module line_buffer SHALL be a single-row circular buffer (MAX_WIDTH x PIX_W, read-before-write at index col) and SHALL be instantiated twice.

Verification
REQ-032 4x4 frame with pixel = index (0..15) and pixel_valid held high -> the first conv_en follows the accept of pixel 10, with sample_out=0xA98654210; a multiplier/adder with all-ones coefficients yields 45.
REQ-033 Same frame -> exactly 4 conv_en pulses, each followed by a pixel_ready low window of exactly 2 cycles; frame_done pulses once after pixel 15.
REQ-034 Random pixel_valid gaps on a 16x3 frame -> 14 windows with values identical to the gap-free run.
REQ-035 img_width=2 -> cfg_err=1, zero conv_en, frame_done after 6 accepts.
REQ-036 clear asserted in the ISSUE cycle mid-frame -> conv_en low the next cycle, counters at 0, and the next frame correct.
REQ-037 n_rst pulsed mid-frame -> all outputs at reset values immediately, and a clean restart follows.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg -- shared constants and types for the 3x3 convolution window
// front end.
//   PIX_W    : bits per pixel
//   KERNEL   : window edge length (3x3 window)
//   window_t : packed 3x3 window, nibble k = 3*r + c at bits [4k+3:4k]
//   state_t  : window issue FSM states
package conv_pkg;
   localparam int PIX_W  = 4;
   localparam int KERNEL = 3;

   typedef logic [35:0] window_t;

   typedef enum logic [1:0] {
      ACCEPT = 2'd0,
      ISSUE  = 2'd1,
      HOLD   = 2'd2
   } state_t;
endpackage

// File: rtl/conv_window_line_buffer.sv
// line_buffer -- one image row of pixels as a circular buffer indexed by
// the column counter. The read at idx is combinational and returns the
// value stored one row ago; the write of the new value lands on the clock
// edge, so a single index gives read-before-write behaviour.
//   clk   : rising-edge clock
//   wr_en : write din at idx on this edge
//   idx   : column index
//   din   : pixel to store
//   dout  : pixel stored at idx during the previous row
// Contents are never reset; stale entries are never issued downstream.
module line_buffer
   import conv_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    idx,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] dout
);

   logic [PIX_W-1:0] mem_q [DEPTH];

   assign dout = mem_q[idx];

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[idx] <= din;
   end

endmodule

// File: rtl/conv_window.sv
// conv_window -- builds a sliding 3x3 pixel window from a raster-order
// pixel stream and hands each complete window to a multiplier/adder.
//   clk, n_rst  : clock, asynchronous active-low reset
//   clear       : synchronous frame abort; wins over a same-cycle accept
//   img_width   : frame width, sampled with the first pixel (legal 3..MAX_WIDTH)
//   img_height  : frame height, sampled with the first pixel (legal 3..31)
//   pixel_in    : pixel data, accepted on pixel_valid & pixel_ready
//   pixel_ready : high only while waiting for a pixel
//   sample_out  : 3x3 window, nibble 8 = newest pixel, stable ISSUE..HOLD
//   conv_en     : one-cycle strobe, window valid
//   frame_done  : one-cycle pulse after the last pixel of a frame
//   cfg_err     : illegal geometry for the frame in progress
// Each complete window costs two stall cycles (ISSUE, then HOLD for the
// multiplier/adder result) during which no pixel is taken.
module conv_window
   import conv_pkg::*;
#(
   parameter int MAX_WIDTH = 16
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        clear,
   input  logic [4:0]  img_width,
   input  logic [4:0]  img_height,
   input  logic [3:0]  pixel_in,
   input  logic        pixel_valid,
   output logic        pixel_ready,
   output logic [35:0] sample_out,
   output logic        conv_en,
   output logic        frame_done,
   output logic        cfg_err
);

   localparam int         AW   = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam logic [4:0] MAXW = 5'(MAX_WIDTH);

   state_t     state_q, state_d;
   logic [4:0] col_q, col_d, row_q, row_d;
   logic [4:0] w_q, w_d, h_q, h_d;
   logic       cfg_err_q, cfg_err_d;
   logic       done_q, done_d;
   window_t    win_q, win_d;

   logic             accept, first_pix, col_last, row_last, geo_bad;
   logic [4:0]       w_clamp, h_clamp;
   logic [PIX_W-1:0] lb1_rd, lb2_rd;
   logic [PIX_W-1:0] tap [KERNEL];

   // Ready depends on the registered state only, so accept has no
   // combinational path back through the FSM.
   assign accept    = pixel_valid & (state_q == ACCEPT) & ~clear;
   assign first_pix = (row_q == 5'd0) && (col_q == 5'd0);
   // At the first pixel w_q may still hold the previous frame's width, but
   // col 0 can never be the last column because every stored width is >= 3.
   assign col_last  = (col_q == w_q - 5'd1);
   assign row_last  = (row_q == h_q - 5'd1);

   assign geo_bad = (img_width < 5'd3) || (img_width > MAXW) || (img_height < 5'd3);
   // Illegal widths are clamped so the bad frame still ends at a
   // predictable pixel count and the line buffers stay in range.
   assign w_clamp = (img_width < 5'd3) ? 5'd3 : (img_width > MAXW) ? MAXW : img_width;
   assign h_clamp = (img_height == 5'd0) ? 5'd1 : img_height;

   // Two chained rows: lb1 holds row-1, lb2 receives what lb1 held (row-2).
   line_buffer #(.DEPTH(MAX_WIDTH), .AW(AW)) u_lb1 (
      .clk   (clk),
      .wr_en (accept),
      .idx   (col_q[AW-1:0]),
      .din   (pixel_in),
      .dout  (lb1_rd)
   );

   line_buffer #(.DEPTH(MAX_WIDTH), .AW(AW)) u_lb2 (
      .clk   (clk),
      .wr_en (accept),
      .idx   (col_q[AW-1:0]),
      .din   (lb1_rd),
      .dout  (lb2_rd)
   );

   assign tap[0] = lb2_rd;
   assign tap[1] = lb1_rd;
   assign tap[2] = pixel_in;

   // Shift every window row one column toward the oldest position and
   // load the newest column from the line buffers and the incoming pixel.
   always_comb begin
      win_d = win_q;
      if (accept) begin
         for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL - 1; c++)
               win_d[PIX_W*(KERNEL*r+c) +: PIX_W] = win_q[PIX_W*(KERNEL*r+c+1) +: PIX_W];
            win_d[PIX_W*(KERNEL*r+KERNEL-1) +: PIX_W] = tap[r];
         end
      end
   end

   // Raster position, sampled geometry and error flag.
   always_comb begin
      col_d     = col_q;
      row_d     = row_q;
      w_d       = w_q;
      h_d       = h_q;
      cfg_err_d = cfg_err_q;
      done_d    = 1'b0;
      if (clear) begin
         col_d     = 5'd0;
         row_d     = 5'd0;
         cfg_err_d = 1'b0;
      end else if (accept) begin
         if (first_pix) begin
            w_d       = w_clamp;
            h_d       = h_clamp;
            cfg_err_d = geo_bad;
         end
         if (col_last) begin
            col_d = 5'd0;
            if (row_last) begin
               row_d     = 5'd0;
               cfg_err_d = 1'b0;
               done_d    = 1'b1;
            end else begin
               row_d = row_q + 5'd1;
            end
         end else begin
            col_d = col_q + 5'd1;
         end
      end
   end

   // Window issue FSM.
   always_comb begin
      state_d     = state_q;
      pixel_ready = 1'b0;
      conv_en     = 1'b0;
      unique case (state_q)
         ACCEPT: begin
            pixel_ready = 1'b1;
            // A window is complete once two earlier rows and columns exist.
            if (accept && (row_q >= 5'd2) && (col_q >= 5'd2) && !cfg_err_q)
               state_d = ISSUE;
         end
         ISSUE: begin
            conv_en = 1'b1;
            state_d = HOLD;
         end
         HOLD:    state_d = ACCEPT;
         default: state_d = ACCEPT;
      endcase
      if (clear) state_d = ACCEPT;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= ACCEPT;
         col_q     <= 5'd0;
         row_q     <= 5'd0;
         w_q       <= 5'd3;
         h_q       <= 5'd3;
         cfg_err_q <= 1'b0;
         done_q    <= 1'b0;
         win_q     <= '0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         w_q       <= w_d;
         h_q       <= h_d;
         cfg_err_q <= cfg_err_d;
         done_q    <= done_d;
         win_q     <= win_d;
      end
   end

   assign sample_out = win_q;
   assign frame_done = done_q;
   assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_conv_window.sv
// tb_conv_window -- directed stimulus for conv_window. A raster-image model
// records every accepted pixel at (row, col) and predicts, cycle by cycle,
// the strobe, ready, frame_done and cfg_err outputs and each 3x3 window;
// literal checks pin known windows and pulse counts.
module tb_conv_window;

   localparam int MW = 16;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        clear = 1'b0;
   logic [4:0]  img_width = 5'd4;
   logic [4:0]  img_height = 5'd4;
   logic [3:0]  pixel_in = 4'd0;
   logic        pixel_valid = 1'b0;
   logic        pixel_ready;
   logic [35:0] sample_out;
   logic        conv_en;
   logic        frame_done;
   logic        cfg_err;

   always #5 clk = ~clk;

   conv_window #(.MAX_WIDTH(MW)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .clear       (clear),
      .img_width   (img_width),
      .img_height  (img_height),
      .pixel_in    (pixel_in),
      .pixel_valid (pixel_valid),
      .pixel_ready (pixel_ready),
      .sample_out  (sample_out),
      .conv_en     (conv_en),
      .frame_done  (frame_done),
      .cfg_err     (cfg_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // ---------------- image model ----------------
   logic [3:0]  img [32][16];
   int          m_row, m_col, m_w, m_h, phase;
   bit          m_err;
   bit          exp_conv, exp_ready, exp_done, exp_err, chk_win, prev_conv;
   logic [35:0] exp_win;

   int          conv_cnt = 0, done_cnt = 0, low_cnt = 0, err_seen = 0;
   logic [35:0] got_q [$];

   function automatic logic [35:0] win_of(input int r0, input int c0);
      logic [35:0] w;
      w = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w[4*(3*r+c) +: 4] = img[r0-2+r][c0-2+c];
      return w;
   endfunction

   always @(negedge clk) begin
      bit acc, win, last;
      logic [35:0] wv;
      if (!n_rst) begin
         m_row = 0; m_col = 0; m_err = 0; phase = 0;
         exp_conv = 0; exp_ready = 1; exp_done = 0; exp_err = 0;
         exp_win = '0; chk_win = 1; prev_conv = 0;
      end else begin
         chk("conv_en", conv_en, exp_conv);
         chk("pixel_ready", pixel_ready, exp_ready);
         chk("frame_done", frame_done, exp_done);
         chk("cfg_err", cfg_err, exp_err);
         if (chk_win) chk("sample_out", sample_out, exp_win);
         chk("conv_en_back_to_back", prev_conv & conv_en, 1'b0);
         if (conv_en) begin conv_cnt++; got_q.push_back(sample_out); end
         if (frame_done) done_cnt++;
         if (!pixel_ready) low_cnt++;
         if (cfg_err) err_seen++;
         prev_conv = conv_en;

         // predict the cycle after the coming edge
         acc = pixel_valid && exp_ready && !clear;
         win = 0; last = 0; wv = '0;
         if (clear) begin
            m_row = 0; m_col = 0; m_err = 0; phase = 0;
            exp_conv = 0; exp_ready = 1; exp_done = 0; exp_err = 0; chk_win = 0;
         end else begin
            if (acc) begin
               if (m_row == 0 && m_col == 0) begin
                  m_w   = (img_width < 3) ? 3 : (img_width > MW) ? MW : int'(img_width);
                  m_h   = (img_height == 0) ? 1 : int'(img_height);
                  m_err = (img_width < 3) || (img_width > MW) || (img_height < 3);
               end
               img[m_row][m_col] = pixel_in;
               win  = (m_row >= 2) && (m_col >= 2) && !m_err;
               if (win) wv = win_of(m_row, m_col);
               last = (m_row == m_h - 1) && (m_col == m_w - 1);
               if (m_col == m_w - 1) begin
                  m_col = 0;
                  m_row = last ? 0 : m_row + 1;
               end else begin
                  m_col++;
               end
               if (last) m_err = 0;
            end
            exp_done = last;
            exp_err  = m_err;
            case (phase)
               0: if (win) begin
                     phase = 1; exp_conv = 1; exp_ready = 0; exp_win = wv; chk_win = 1;
                  end else begin
                     exp_conv = 0; exp_ready = 1; chk_win = 0;
                  end
               1: begin phase = 2; exp_conv = 0; exp_ready = 0; chk_win = 1; end
               default: begin phase = 0; exp_conv = 0; exp_ready = 1; chk_win = 0; end
            endcase
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push(input logic [3:0] p, input int gap);
      bit acc, ok;
      pixel_valid = 0;
      step(gap);
      pixel_valid = 1;
      pixel_in = p;
      ok = 0;
      for (int t = 0; t < 8 && !ok; t++) begin
         @(negedge clk);
         acc = pixel_ready;
         @(posedge clk); #1;
         if (acc) ok = 1;
      end
      pixel_valid = 0;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL push_timeout: pixel %0d not accepted within 8 cycles", p);
      end
   endtask

   function automatic logic [3:0] pix(input int mode, input int i);
      return (mode == 0) ? 4'(i) : 4'(i * 7 + 3);
   endfunction

   // Sends npix pixels of a frame; gaps > 0 inserts random idle cycles.
   task automatic frame(input int w, input int h, input int npix, input int mode, input int gaps);
      img_width  = 5'(w);
      img_height = 5'(h);
      for (int i = 0; i < npix; i++)
         push(pix(mode, i), (gaps > 0) ? int'($urandom_range(0, gaps)) : 0);
   endtask

   logic [35:0] ref_win [14];

   initial begin
      int c0, d0, l0, q0, e0, s;
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c0, d0, l0, q0, e0, s;
      // reset state
      @(posedge clk); #1;
      chk("rst_conv_en", conv_en, 1'b0);
      chk("rst_pixel_ready", pixel_ready, 1'b1);
      chk("rst_sample_out", sample_out, 36'h0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_cfg_err", cfg_err, 1'b0);
      step(1);
      n_rst = 1;
      step(2);

      // 4x4 index frame
      c0 = conv_cnt; d0 = done_cnt; l0 = low_cnt; q0 = got_q.size();
      frame(4, 4, 16, 0, 0);
      step(4);
      chk("f4x4_windows", conv_cnt - c0, 4);
      chk("f4x4_frame_done", done_cnt - d0, 1);
      chk("f4x4_ready_low", low_cnt - l0, 8);
      if (got_q.size() >= q0 + 4) begin
         chk("f4x4_win0", got_q[q0], 36'hA98654210);
         s = 0;
         for (int k = 0; k < 9; k++) s += int'(got_q[q0][4*k +: 4]);
         chk("f4x4_sum0", s, 45);
         chk("f4x4_win1", got_q[q0+1], 36'hBA9765321);
         chk("f4x4_win3", got_q[q0+3], 36'hFEDBA9765);
      end else begin
         chk("f4x4_win_count", got_q.size() - q0, 4);
      end

      // 16x3 gap-free, then with random gaps
      q0 = got_q.size();
      frame(16, 3, 48, 1, 0);
      step(4);
      chk("f16x3_windows", got_q.size() - q0, 14);
      for (int i = 0; i < 14; i++) ref_win[i] = (q0 + i < got_q.size()) ? got_q[q0+i] : '0;
      q0 = got_q.size();
      frame(16, 3, 48, 1, 2);
      step(4);
      chk("f16x3_gap_windows", got_q.size() - q0, 14);
      if (got_q.size() >= q0 + 14)
         for (int i = 0; i < 14; i++) chk("f16x3_gap_match", got_q[q0+i], ref_win[i]);

      // illegal width: clamped to 3, height 2 -> 6 pixels, no windows
      c0 = conv_cnt; d0 = done_cnt; e0 = err_seen;
      frame(2, 2, 6, 0, 0);
      step(3);
      chk("bad_geo_windows", conv_cnt - c0, 0);
      chk("bad_geo_frame_done", done_cnt - d0, 1);
      chk("bad_geo_err_seen", err_seen > e0, 1'b1);
      chk("bad_geo_err_cleared", cfg_err, 1'b0);

      // clear during ISSUE mid-frame
      frame(5, 4, 13, 0, 0);
      chk("clr_in_issue", conv_en, 1'b1);
      clear = 1;
      step(1);
      clear = 0;
      chk("clr_conv_drop", conv_en, 1'b0);
      chk("clr_ready", pixel_ready, 1'b1);
      c0 = conv_cnt; q0 = got_q.size();
      frame(4, 4, 16, 0, 0);
      step(4);
      chk("clr_next_windows", conv_cnt - c0, 4);
      if (got_q.size() > q0) chk("clr_next_win0", got_q[q0], 36'hA98654210);

      // reset pulse mid-frame while a window is being issued
      frame(4, 4, 11, 0, 0);
      #2 n_rst = 0;
      #1;
      chk("mid_rst_conv_en", conv_en, 1'b0);
      chk("mid_rst_ready", pixel_ready, 1'b1);
      chk("mid_rst_sample", sample_out, 36'h0);
      chk("mid_rst_done", frame_done, 1'b0);
      chk("mid_rst_err", cfg_err, 1'b0);
      step(2);
      n_rst = 1;
      step(1);
      c0 = conv_cnt; d0 = done_cnt; q0 = got_q.size();
      frame(4, 4, 16, 0, 0);
      step(4);
      chk("post_rst_windows", conv_cnt - c0, 4);
      chk("post_rst_done", done_cnt - d0, 1);
      if (got_q.size() > q0) chk("post_rst_win0", got_q[q0], 36'hA98654210);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
